kypd_scan: RTL and testbench

//  Scanner for a 4x4 matrix keypad on a PMOD header (Digilent KYPD layout).
//  - Drives one column low at a time and samples the active-low rows.
//  - Debounces whole-matrix snapshots over several full scans.
//  - Reports a single hex key code with a valid level, a press strobe and a multi-key flag.
//  - Input-side counterpart of the StickIt LED digit driver: keypad in, LED digits out.

---
 rtl/kypd_pkg.sv | 57 +++++
 rtl/kypd_scan_sync2.sv | 25 ++
 rtl/kypd_scan.sv | 173 +++++++++++++++++
 tb/tb_kypd_scan.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry,
// key-code table and bit-counting helpers for the debounced matrix.
package kypd_pkg;

   localparam int unsigned KYPD_ROWS = 4;
   localparam int unsigned KYPD_COLS = 4;
   localparam int unsigned KYPD_KEYS = KYPD_ROWS * KYPD_COLS;

   // Column currently driven low
   typedef enum logic [1:0] {
      COL0 = 2'd0,
      COL1 = 2'd1,
      COL2 = 2'd2,
      COL3 = 2'd3
   } col_state_t;

   // Key code indexed by r*4+c (Digilent KYPD legend)
   localparam logic [3:0] KEY_MAP [KYPD_KEYS] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'h0, 4'hF, 4'hE, 4'hD
   };

   // Number of pressed keys in a matrix snapshot
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

   // True when exactly one key is pressed
   function automatic logic is_onehot16(input logic [15:0] v);
      return popcount16(v) == 5'd1;
   endfunction

   // Key code for a snapshot; snapshot bit 4*c+r holds key (r,c).
   // Only meaningful for a one-hot snapshot.
   function automatic logic [3:0] key_code(input logic [15:0] v);
      logic [3:0] k;
      logic [3:0] bi;
      logic [3:0] idx;
      k = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         bi  = 4'(i);
         idx = {bi[1:0], bi[3:2]};
         if (v[i]) begin
            k = KEY_MAP[idx];
         end
      end
      return k;
   endfunction

endpackage

// File: rtl/kypd_scan_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two register stages to resolve metastability
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/kypd_scan.sv
// 4x4 keypad scanner: walks one active-low column at a time, samples the
// synchronized rows into a whole-matrix snapshot, debounces over several
// identical full scans and decodes a single key / multi-key result.
module kypd_scan
   import kypd_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [KYPD_ROWS-1:0] ROW,
   output logic [KYPD_COLS-1:0] COL,
   output logic [3:0]           KEY,
   output logic                 KEY_VALID,
   output logic                 KEY_PRESS,
   output logic                 MULTI
);

   localparam int unsigned     SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned     DW          = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0]   STABLE_MAX  = DW'(DEBOUNCE_SCANS);

   col_state_t          col_state;
   col_state_t          col_next;
   logic [SW-1:0]       settle_cnt;
   logic [KYPD_ROWS-1:0] row_sync;
   logic [KYPD_ROWS-1:0] row_pressed;
   logic                col_done;
   logic                scan_done;
   logic [3:0]          col_base;

   logic [15:0]         snapshot;
   logic [15:0]         snap_full;
   logic [15:0]         candidate;
   logic [DW-1:0]       stable_cnt;
   logic [DW-1:0]       stable_next;
   logic                snap_match;
   logic [15:0]         debounced;
   logic [15:0]         deb_prev;
   logic [4:0]          deb_pop;

   sync2 #(
      .WIDTH   (KYPD_ROWS),
      .RST_VAL ('1)
   ) u_row_sync (
      .clk (CLK),
      .rst (RESET),
      .d   (ROW),
      .q   (row_sync)
   );

   assign row_pressed = ~row_sync;
   assign col_done    = (settle_cnt == SETTLE_LAST);
   assign scan_done   = col_done && (col_state == COL3);
   assign col_base    = {col_state, 2'b00};

   // Column state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         col_state <= COL0;
      end else begin
         col_state <= col_next;
      end
   end

   // Advance to the next column once the current one has settled
   always_comb begin
      col_next = col_state;
      if (col_done) begin
         unique case (col_state)
            COL0: col_next = COL1;
            COL1: col_next = COL2;
            COL2: col_next = COL3;
            COL3: col_next = COL0;
         endcase
      end
   end

   // Drive exactly one column low
   always_comb begin
      COL = 4'b1110;
      unique case (col_state)
         COL0: COL = 4'b1110;
         COL1: COL = 4'b1101;
         COL2: COL = 4'b1011;
         COL3: COL = 4'b0111;
      endcase
   end

   // Settle timer for the driven column
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         settle_cnt <= '0;
      end else if (col_done) begin
         settle_cnt <= '0;
      end else begin
         settle_cnt <= settle_cnt + SW'(1);
      end
   end

   // Capture the settled rows into this column's snapshot slice
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         snapshot <= '0;
      end else if (col_done) begin
         snapshot[col_base +: 4] <= row_pressed;
      end
   end

   // Snapshot as it will be once column 3 is written: the scan-end compare
   // must see this cycle's column-3 sample, not last scan's.
   always_comb begin
      snap_full             = snapshot;
      snap_full[12 +: 4]    = row_pressed;
   end

   assign snap_match = (snap_full == candidate);

   // Consecutive-identical-scan count, saturating at the accept threshold
   always_comb begin
      stable_next = stable_cnt;
      if (scan_done) begin
         if (!snap_match) begin
            stable_next = DW'(1);
         end else if (stable_cnt != STABLE_MAX) begin
            stable_next = stable_cnt + DW'(1);
         end
      end
   end

   // Debounce registers; on acceptance snap_full equals the candidate
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         candidate  <= '0;
         stable_cnt <= '0;
         debounced  <= '0;
      end else begin
         stable_cnt <= stable_next;
         if (scan_done) begin
            if (!snap_match) begin
               candidate <= snap_full;
            end
            if (stable_next == STABLE_MAX) begin
               debounced <= snap_full;
            end
         end
      end
   end

   assign deb_pop = popcount16(debounced);

   // Registered decode of the debounced matrix
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         deb_prev  <= '0;
         KEY       <= '0;
         KEY_VALID <= 1'b0;
         KEY_PRESS <= 1'b0;
         MULTI     <= 1'b0;
      end else begin
         deb_prev  <= debounced;
         KEY_VALID <= (deb_pop == 5'd1);
         MULTI     <= (deb_pop >= 5'd2);
         KEY_PRESS <= is_onehot16(debounced) && (debounced != deb_prev);
         if (deb_pop == 5'd1) begin
            KEY <= key_code(debounced);
         end
      end
   end

endmodule

// File: tb/tb_kypd_scan.sv
// Self-checking bench for kypd_scan: ideal keypad model drives ROW from COL,
// a scan-level reference model predicts every output each cycle, and
// directed scenarios pin key codes, strobes and latency.
module tb_kypd_scan;

   localparam int unsigned S    = 4;
   localparam int unsigned D    = 3;
   localparam int unsigned SCAN = 4 * S;
   localparam int unsigned LAT  = (D + 1) * SCAN + 3;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [3:0]  KEY;
   logic        KEY_VALID;
   logic        KEY_PRESS;
   logic        MULTI;

   // Pressed keys, bit r*4+c
   logic [15:0] held = '0;

   int checks = 0;
   int errors = 0;
   int press_cnt = 0;

   logic [3:0] key_tbl [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   kypd_scan #(
      .SETTLE_CYCLES  (S),
      .DEBOUNCE_SCANS (D)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .ROW       (ROW),
      .COL       (COL),
      .KEY       (KEY),
      .KEY_VALID (KEY_VALID),
      .KEY_PRESS (KEY_PRESS),
      .MULTI     (MULTI)
   );

   always #5 CLK = ~CLK;

   // Ideal keypad: a row is pulled low if a held key joins it to a low column
   function automatic logic [3:0] keypad_rows(input logic [3:0] col, input logic [15:0] h);
      logic [3:0] rows;
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col[c] && h[r*4+c]) rows[r] = 1'b0;
      return rows;
   endfunction

   assign ROW = keypad_rows(COL, held);

   function automatic logic [3:0] key_of(input logic [15:0] m);
      logic [3:0] k;
      k = 4'h0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (m[r*4+c]) k = key_tbl[r][c];
      return k;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (scan level) ----------------
   int unsigned m_edges;
   int unsigned m_run;
   int unsigned m_c;
   logic [15:0] m_h1, m_h2, m_snap, m_last, m_deb, m_prev;
   logic [3:0]  e_col, e_key;
   logic        e_valid, e_press, e_multi;
   int          m_n;

   initial begin
      m_edges = 0; m_run = 0; m_c = 0;
      m_h1 = '0; m_h2 = '0; m_snap = '0; m_last = '0; m_deb = '0; m_prev = '0;
      e_col = 4'b1110; e_key = '0; e_valid = 0; e_press = 0; e_multi = 0;
   end

   always @(posedge CLK) begin
      if (RESET) begin
         m_edges = 0; m_run = 0;
         m_h1 = '0; m_h2 = '0; m_snap = '0; m_last = '0; m_deb = '0; m_prev = '0;
         e_key = '0; e_valid = 0; e_press = 0; e_multi = 0;
      end else begin
         // outputs reflect the debounced matrix as it stood before this edge
         m_n     = $countones(m_deb);
         e_valid = (m_n == 1);
         e_multi = (m_n >= 2);
         e_press = (m_n == 1) && (m_deb != m_prev);
         if (m_n == 1) e_key = key_of(m_deb);
         m_prev = m_deb;
         // last settle cycle of a column: rows seen are the keypad two edges ago
         if (m_edges % S == S - 1) begin
            m_c = (m_edges / S) % 4;
            for (int r = 0; r < 4; r++) m_snap[r*4+m_c] = m_h2[r*4+m_c];
            if (m_c == 3) begin
               if (m_run > 0 && m_snap == m_last) m_run++;
               else begin
                  m_run  = 1;
                  m_last = m_snap;
               end
               if (m_run >= D) m_deb = m_last;
            end
         end
         m_h2 = m_h1;
         m_h1 = held;
         m_edges++;
      end
      e_col = ~(4'b0001 << ((m_edges / S) % 4));
   end

   // Per-cycle comparison against the model
   always @(posedge CLK) begin
      #1;
      chk("cyc_COL", COL, e_col);
      chk("cyc_KEY", KEY, e_key);
      chk("cyc_KEY_VALID", {3'b0, KEY_VALID}, {3'b0, e_valid});
      chk("cyc_KEY_PRESS", {3'b0, KEY_PRESS}, {3'b0, e_press});
      chk("cyc_MULTI", {3'b0, MULTI}, {3'b0, e_multi});
   end

   always @(posedge CLK) begin
      #1;
      if (KEY_PRESS === 1'b1) press_cnt++;
   end

   // ---------------- directed helpers ----------------
   task automatic wait_press(input string name, input int unsigned budget, output int unsigned cycles);
      bit seen;
      seen = 0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(posedge CLK); #1;
         cycles++;
         if (KEY_PRESS === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s no KEY_PRESS within %0d cycles", name, budget);
      end
   endtask

   // sel 0: wait KEY_VALID==0, sel 1: wait MULTI==1
   task automatic wait_level(input string name, input int sel, input int unsigned budget);
      bit seen;
      int unsigned cycles;
      seen = 0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(posedge CLK); #1;
         cycles++;
         if (sel == 0 && KEY_VALID === 1'b0) seen = 1;
         if (sel == 1 && MULTI === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s level not reached within %0d cycles", name, budget);
      end
   endtask

   logic [3:0] walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   initial begin
      int unsigned cyc;
      int unsigned dur;
      int unsigned k1, k2;

      // 1: reset state and column walk
      RESET = 1'b1;
      held  = '0;
      repeat (3) @(negedge CLK);
      chk("rst_COL", COL, 4'b1110);
      chk("rst_KEY", KEY, 4'h0);
      chk("rst_KEY_VALID", {3'b0, KEY_VALID}, 4'h0);
      chk("rst_KEY_PRESS", {3'b0, KEY_PRESS}, 4'h0);
      chk("rst_MULTI", {3'b0, MULTI}, 4'h0);
      @(negedge CLK);
      RESET = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         chk("walk_COL", COL, walk[((k + 1) / 4) % 4]);
      end

      // 2: clean press of '5', held for 20 scans
      @(negedge CLK);
      press_cnt = 0;
      held[1*4+1] = 1'b1;
      wait_press("press5", LAT, cyc);
      chk("press5_KEY", KEY, 4'h5);
      chk("press5_VALID", {3'b0, KEY_VALID}, 4'h1);
      chk("press5_MULTI", {3'b0, MULTI}, 4'h0);
      repeat (20 * SCAN) @(negedge CLK);
      chk_int("hold5_strobes", press_cnt, 1);

      // 3: bouncing 'D'; toggle period is shorter than a scan so no three
      // consecutive scans agree, then the key settles
      held = '0;
      wait_level("release5", 0, LAT);
      repeat (2 * SCAN) @(negedge CLK);
      press_cnt = 0;
      for (int k = 0; k < 5 * SCAN; k++) begin
         @(negedge CLK);
         if (k % 6 == 0) held[15] = ~held[15];
      end
      chk_int("bounceD_strobes", press_cnt, 0);
      held[15] = 1'b1;
      wait_press("steadyD", LAT, cyc);
      chk("steadyD_KEY", KEY, 4'hD);
      repeat (3 * SCAN) @(negedge CLK);
      chk_int("steadyD_strobes", press_cnt, 1);

      // 4: '1' plus 'A' together, then release 'A'
      press_cnt = 0;
      held = '0;
      held[0] = 1'b1;
      held[3] = 1'b1;
      wait_level("multi1A", 1, LAT);
      chk("multi_VALID", {3'b0, KEY_VALID}, 4'h0);
      repeat (2 * SCAN) @(negedge CLK);
      chk_int("multi_strobes", press_cnt, 0);
      chk("multi_KEY_hold", KEY, 4'hD);
      held[3] = 1'b0;
      wait_press("releaseA", LAT, cyc);
      chk("releaseA_KEY", KEY, 4'h1);
      chk("releaseA_VALID", {3'b0, KEY_VALID}, 4'h1);
      chk("releaseA_MULTI", {3'b0, MULTI}, 4'h0);

      // 5: release all, KEY holds; then '0'
      @(negedge CLK);
      held = '0;
      wait_level("release_all", 0, LAT);
      chk("release_all_KEY", KEY, 4'h1);
      @(negedge CLK);
      held[3*4+0] = 1'b1;
      wait_press("press0", LAT, cyc);
      chk("press0_KEY", KEY, 4'h0);
      chk("press0_VALID", {3'b0, KEY_VALID}, 4'h1);

      // 6: reset mid-column with '7' held
      @(negedge CLK);
      held = '0;
      held[2*4+0] = 1'b1;
      wait_press("press7", LAT, cyc);
      chk("press7_KEY", KEY, 4'h7);
      repeat (SCAN + 2) @(negedge CLK);
      RESET = 1'b1;
      #1;
      chk("midrst_COL", COL, 4'b1110);
      chk("midrst_KEY", KEY, 4'h0);
      chk("midrst_VALID", {3'b0, KEY_VALID}, 4'h0);
      chk("midrst_MULTI", {3'b0, MULTI}, 4'h0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      press_cnt = 0;
      wait_press("after_rst7", LAT, cyc);
      checks++;
      if (cyc < 3 * SCAN) begin
         errors++;
         $display("FAIL after_rst7_latency got %0d expected >= %0d", cyc, 3 * SCAN);
      end
      chk("after_rst7_KEY", KEY, 4'h7);
      repeat (2 * SCAN) @(negedge CLK);
      chk_int("after_rst7_strobes", press_cnt, 1);

      // Randomized key patterns, including sub-scan glitches
      for (int it = 0; it < 40; it++) begin
         @(negedge CLK);
         held = '0;
         k1 = $urandom_range(0, 15);
         k2 = $urandom_range(0, 15);
         case ($urandom_range(0, 3))
            0: ;
            1, 2: held[k1] = 1'b1;
            default: begin
               held[k1] = 1'b1;
               held[k2] = 1'b1;
            end
         endcase
         dur = $urandom_range(3, 6 * SCAN);
         repeat (dur) @(negedge CLK);
      end
      held = '0;
      repeat (5 * SCAN) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
